// File: rtl/core_pkg.sv
// core_pkg: definitions shared by the fetch, decode and execute stages of the
// multi-cycle core.
//   PC_W_DEF      default PC / instruction-memory word-address width
//   INSTR_W       instruction word width
//   fetch_state_e fetch stage FSM encoding
package core_pkg;

  localparam int PC_W_DEF = 15;
  localparam int INSTR_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory read bus between the fetch stage and the
// instruction BRAM.
//   en     read strobe, one cycle per request (fetch -> memory)
//   addr   word address of the read (fetch -> memory)
//   rdata  read data, valid a fixed latency after en (memory -> fetch)
// Modports: master = fetch stage, slave = memory.
interface fetch_if #(
  parameter int PC_W = core_pkg::PC_W_DEF
);

  logic                         en;
  logic [PC_W-1:0]              addr;
  logic [core_pkg::INSTR_W-1:0] rdata;

  modport master (output en, output addr, input rdata);
  modport slave  (input en, input addr, output rdata);

endinterface

// File: rtl/fetch.sv
// fetch: instruction-fetch stage. On an enable pulse in IDLE it reads one word
// from instruction memory at the current PC, presents it on command with a
// one-cycle done pulse, and advances the PC. A redirect reloads the PC and
// cancels any fetch in flight; the cancelled fetch is replaced automatically
// by a fetch from the new PC.
// Ports:
//   clk, rstn    clock, synchronous active-low reset
//   enable       start-fetch pulse, honoured only when idle
//   done         one-cycle pulse, command/pc_out valid from this cycle
//   busy         high whenever the FSM is not idle
//   command      last fetched instruction
//   pc_out       word address of command
//   redirect     PC-load pulse; redirect_pc is the new PC
//   imem         instruction-memory read bus (master side)
module fetch
  import core_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              MEM_LAT  = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  output logic               done,
  output logic               busy,
  output logic [INSTR_W-1:0] command,
  output logic [PC_W-1:0]    pc_out,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  fetch_if.master            imem
);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_REQ  = 2'(REQ);
  localparam logic [1:0] ST_WAIT = 2'(WAIT);

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               kill_q, kill_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [INSTR_W-1:0] command_q, command_d;
  logic [PC_W-1:0]    pc_out_q, pc_out_d;
  logic               imem_en_q, imem_en_d;
  logic [PC_W-1:0]    imem_addr_q, imem_addr_d;

  // Redirect has priority over the current PC wherever a new request is
  // launched, so a redirect in the same cycle as the launch is fetched at once.
  logic [PC_W-1:0] next_pc;
  assign next_pc = redirect ? redirect_pc : pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    command_d   = command_q;
    pc_out_d    = pc_out_q;
    imem_en_d   = 1'b0;
    imem_addr_d = imem_addr_q;

    case (state_q)
      ST_IDLE: begin
        pc_d = next_pc;
        if (enable) begin
          state_d     = ST_REQ;
          imem_en_d   = 1'b1;
          imem_addr_d = next_pc;
        end
      end

      ST_REQ: begin
        state_d = ST_WAIT;
        cnt_d   = 3'(MEM_LAT);
        if (redirect) begin
          pc_d   = redirect_pc;
          kill_d = 1'b1;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (redirect) begin
          pc_d   = redirect_pc;
          kill_d = 1'b1;
        end
        // cnt_q == 1 marks the edge on which memory data is valid. A redirect
        // arriving on that same edge also cancels the returning word.
        if (cnt_q == 3'd1) begin
          if (kill_q || redirect) begin
            kill_d      = 1'b0;
            state_d     = ST_REQ;
            imem_en_d   = 1'b1;
            imem_addr_d = next_pc;
          end else begin
            command_d = imem.rdata;
            pc_out_d  = pc_q;
            pc_d      = pc_q + PC_W'(1);
            done_d    = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      cnt_q       <= 3'd0;
      done_q      <= 1'b0;
      command_q   <= '0;
      pc_out_q    <= '0;
      imem_en_q   <= 1'b0;
      imem_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      command_q   <= command_d;
      pc_out_q    <= pc_out_d;
      imem_en_q   <= imem_en_d;
      imem_addr_q <= imem_addr_d;
    end
  end

  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);
  assign command   = command_q;
  assign pc_out    = pc_out_q;
  assign imem.en   = imem_en_q;
  assign imem.addr = imem_addr_q;

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed self-checking bench for the fetch stage with a
// two-cycle-latency instruction memory model.
module tb_fetch;
  import core_pkg::*;

  localparam int PC_W    = 15;
  localparam int MEM_LAT = 2;

  logic              clk;
  logic              rstn;
  logic              enable;
  logic              done;
  logic              busy;
  logic [31:0]       command;
  logic [PC_W-1:0]   pc_out;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;

  int vec_count  = 0;
  int miscompares = 0;

  logic en_prev   = 1'b0;
  logic en_twice  = 1'b0;
  logic done_busy = 1'b0;

  logic [31:0] s1_data, s2_data;
  logic        s1_valid, s2_valid;

  fetch_if #(.PC_W(PC_W)) imem_bus ();

  fetch #(.PC_W(PC_W), .MEM_LAT(MEM_LAT), .RESET_PC('0)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .enable      (enable),
    .done        (done),
    .busy        (busy),
    .command     (command),
    .pc_out      (pc_out),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem_bus)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of instruction memory: word 0 is the known DEADBEEF pattern,
  // every other word encodes its own address so a wrong fetch is visible.
  function automatic logic [31:0] memWord(input logic [PC_W-1:0] a);
    if (a == '0) return 32'hDEADBEEF;
    return {8'hA5, 9'h000, a};
  endfunction

  // Memory model: request sampled on an edge, data presented MEM_LAT edges
  // later. Outside a valid slot the bus carries garbage so stale or early
  // captures show up in command.
  always @(posedge clk) begin
    s1_valid <= imem_bus.en;
    s1_data  <= memWord(imem_bus.addr);
    s2_valid <= s1_valid;
    s2_data  <= s1_data;
  end
  assign imem_bus.rdata = s2_valid ? s2_data : 32'hBAD00BAD;

  // Protocol monitor: remembers if imem_en was ever high two cycles running
  // or if done and busy were ever high together.
  always @(negedge clk) begin
    if (rstn) begin
      if (imem_bus.en && en_prev) en_twice = 1'b1;
      if (done && busy) done_busy = 1'b1;
    end
    en_prev = imem_bus.en;
  end

  // Single comparison point: counts every vector and reports miscompares.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic redir, input logic [PC_W-1:0] rpc);
    enable      = en;
    redirect    = redir;
    redirect_pc = rpc;
  endtask

  // One fetch started in the current cycle; returns in the done cycle so the
  // next call issues its enable back-to-back with this done.
  task automatic fetchOne(input string tag, input logic redir, input logic [PC_W-1:0] rpc,
                          input logic [PC_W-1:0] exp_addr);
    applyStimulus(1'b1, redir, rpc);
    tick();
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput({tag, ".imem_en"}, 32'(imem_bus.en), 32'd1);
    checkOutput({tag, ".imem_addr"}, 32'(imem_bus.addr), 32'(exp_addr));
    checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
    tick();
    tick();
    checkOutput({tag, ".early_done"}, 32'(done), 32'd0);
    tick();
    checkOutput({tag, ".done"}, 32'(done), 32'd1);
    checkOutput({tag, ".command"}, command, memWord(exp_addr));
    checkOutput({tag, ".pc_out"}, 32'(pc_out), 32'(exp_addr));
  endtask

  initial begin
    rstn = 1'b0;
    applyStimulus(1'b0, 1'b0, '0);
    tick();
    tick();
    checkOutput("rst.done", 32'(done), 32'd0);
    checkOutput("rst.busy", 32'(busy), 32'd0);
    checkOutput("rst.imem_en", 32'(imem_bus.en), 32'd0);
    checkOutput("rst.imem_addr", 32'(imem_bus.addr), 32'd0);
    checkOutput("rst.command", command, 32'd0);
    checkOutput("rst.pc_out", 32'(pc_out), 32'd0);
    rstn = 1'b1;
    tick();

    // First fetch from the reset PC, then three back-to-back fetches.
    fetchOne("f0", 1'b0, '0, 15'h0000);
    fetchOne("b2b1", 1'b0, '0, 15'h0001);
    fetchOne("b2b2", 1'b0, '0, 15'h0002);
    fetchOne("b2b3", 1'b0, '0, 15'h0003);
    tick();
    checkOutput("idle.busy", 32'(busy), 32'd0);
    checkOutput("idle.done", 32'(done), 32'd0);

    // Redirect together with enable: the fetch uses the redirect target.
    fetchOne("redir_en", 1'b1, 15'h0100, 15'h0100);

    // Redirect one cycle after imem_en kills the 0x101 fetch and refetches 0x40.
    applyStimulus(1'b1, 1'b0, '0);
    tick();
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("kill.req_addr", 32'(imem_bus.addr), 32'h0101);
    tick();
    applyStimulus(1'b0, 1'b1, 15'h0040);
    tick();
    applyStimulus(1'b0, 1'b0, '0);
    tick();
    checkOutput("kill.no_done", 32'(done), 32'd0);
    checkOutput("kill.cmd_held", command, memWord(15'h0100));
    checkOutput("kill.refetch_en", 32'(imem_bus.en), 32'd1);
    checkOutput("kill.refetch_addr", 32'(imem_bus.addr), 32'h0040);
    tick();
    tick();
    checkOutput("kill.early_done", 32'(done), 32'd0);
    tick();
    checkOutput("kill.done", 32'(done), 32'd1);
    checkOutput("kill.command", command, memWord(15'h0040));
    checkOutput("kill.pc_out", 32'(pc_out), 32'h0040);

    // Redirect alone in IDLE to the top of memory, then wrap to 0.
    applyStimulus(1'b0, 1'b1, 15'h7FFF);
    tick();
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("redir_idle.busy", 32'(busy), 32'd0);
    fetchOne("top", 1'b0, '0, 15'h7FFF);
    fetchOne("wrap", 1'b0, '0, 15'h0000);

    // Reset while waiting for data; the late word must not produce done.
    applyStimulus(1'b1, 1'b0, '0);
    tick();
    applyStimulus(1'b0, 1'b0, '0);
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    checkOutput("rstw.done", 32'(done), 32'd0);
    checkOutput("rstw.busy", 32'(busy), 32'd0);
    checkOutput("rstw.imem_en", 32'(imem_bus.en), 32'd0);
    checkOutput("rstw.imem_addr", 32'(imem_bus.addr), 32'd0);
    checkOutput("rstw.command", command, 32'd0);
    checkOutput("rstw.pc_out", 32'(pc_out), 32'd0);
    tick();
    checkOutput("rstw.stale_done1", 32'(done), 32'd0);
    tick();
    checkOutput("rstw.stale_done2", 32'(done), 32'd0);
    checkOutput("rstw.cmd_clean", command, 32'd0);
    fetchOne("after_rst", 1'b0, '0, 15'h0000);
    tick();

    checkOutput("mon.imem_en_consecutive", 32'(en_twice), 32'd0);
    checkOutput("mon.done_and_busy", 32'(done_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
